mod_fifo_n: RTL and testbench
=============================

// Module: mod_fifo_n
// PURPOSE
//  Parametrised synchronous FIFO; replaces the single-entry byte buffer between the key/state byte stream and the S-box ROM.
//  Holds DEPTH words of WIDTH bits, with push/pop handshakes, full/empty/almost-full flags and an occupancy count.
//  Output is registered: a popped word appears on outp one cycle after the pop request, qualified by out_valid.
// PARAMETERS
//  WIDTH     8           data word width in bits (>=1)
//  DEPTH     16          number of entries; power of 2, >=2
//  AF_LEVEL  DEPTH-2     almost_full asserts when count >= AF_LEVEL (1..DEPTH)
// PORTS
//  clk          in   1                  clock, rising edge
//  resetn       in   1                  reset, asynchronous, active-high (asserted = 1)
//  wr_en        in   1                  push request; accepted when full==0
//  inp          in   WIDTH              push data, sampled with accepted push
//  rd_en        in   1                  pop request (ROM read); accepted when empty==0
//  outp         out  WIDTH              registered pop data
//  out_valid    out  1                  1-cycle pulse: outp updated this cycle
//  empty        out  1                  count==0
//  full         out  1                  count==DEPTH
//  almost_full  out  1                  count>=AF_LEVEL
//  count        out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  err_ovf      out  1                  sticky push-while-full (FIFO_ERR_FLAGS_EN only)
//  err_udf      out  1                  sticky pop-while-empty (FIFO_ERR_FLAGS_EN only)
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer): wptr=rptr=0, count=0, empty=1, full=0,
//    almost_full=0, outp=0, out_valid=0, err flags=0; memory contents not reset, all stored data discarded.
//  - Push accepted iff wr_en && !full (flags as registered at the start of the cycle): mem[wptr]<=inp, wptr+1.
//  - Pop accepted iff rd_en && !empty: outp<=mem[rptr], out_valid<=1 next cycle, rptr+1; else out_valid<=0, outp holds.
//  - Latency: pop request at edge N -> data on outp and out_valid=1 after edge N (1 cycle).
//    Push-to-pop: a word pushed at edge N is poppable from edge N+1 (empty deasserts after edge N).
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally; no wrap bit; full/empty come from count.
//  - count update: push only +1; pop only -1; both accepted: unchanged.
//  - Simultaneous push+pop when empty: push accepted, pop rejected (out_valid=0), count -> 1.
//  - Simultaneous push+pop when full: pop accepted, push rejected (data dropped), count -> DEPTH-1.
//  - Rejected push/pop: no pointer, count, memory or outp change.
//  - empty, full, almost_full, count are registered outputs, all consistent with count after each edge.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined: err_ovf sets on wr_en && full, err_udf sets on rd_en && empty;
//    both sticky until reset; they never block the FIFO.
//  Not defined: err_ovf/err_udf ports absent, no error logic; all other behaviour identical.
// TESTING
//  T1 reset -> empty=1 full=0 count=0 outp=0 out_valid=0; assert reset mid-fill -> same values immediately.
//  T2 push 8'h00..8'h0F (16 cycles) -> full=1, count=16, almost_full from count=14;
//     17th push 8'hAA rejected; pop 16 -> 00..0F in order, 1 cycle latency each, empty=1.
//  T3 wrap: push 10, pop 10, push 16 (8'h20..8'h2F) -> full=1; pop all -> 20..2F in order.
//  T4 empty, push 8'h5A + rd_en same cycle -> out_valid=0, count=1; next cycle rd_en -> outp=8'h5A, out_valid=1.
//  T5 full, push 8'hFF + pop same cycle -> oldest word out, count=15, 8'hFF not stored.
//  T6 FIFO_ERR_FLAGS_EN: pop on empty -> err_udf=1; push on full -> err_ovf=1; both hold until reset.

Source files
------------

// File: rtl/mod_fifo_n_if.sv
// Push/pop handshake bundle for mod_fifo_n; the error flags exist only when
// FIFO_ERR_FLAGS_EN is defined.
interface mod_fifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] inp;
  logic             rd_en;
  logic [WIDTH-1:0] outp;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             err_ovf;
  logic             err_udf;

  modport master (
    output wr_en, inp, rd_en,
    input  outp, out_valid, empty, full, almost_full, count, err_ovf, err_udf
  );
  modport slave (
    input  wr_en, inp, rd_en,
    output outp, out_valid, empty, full, almost_full, count, err_ovf, err_udf
  );
`else
  modport master (
    output wr_en, inp, rd_en,
    input  outp, out_valid, empty, full, almost_full, count
  );
  modport slave (
    input  wr_en, inp, rd_en,
    output outp, out_valid, empty, full, almost_full, count
  );
`endif
endinterface

// File: rtl/mod_fifo_n.sv
// Synchronous FIFO with registered pop data and count-derived flags.
// Optional sticky overflow/underflow flags under FIFO_ERR_FLAGS_EN.
module mod_fifo_n #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic         clk,
  input logic         resetn,
  mod_fifo_n_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  // Acceptance uses the flags registered at the start of the cycle.
  assign push = bus.wr_en && !full_q;
  assign pop  = bus.rd_en && !empty_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    outp_d      = outp_q;
    out_valid_d = 1'b0;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d      = rptr_q + AW'(1);
      outp_d      = mem[rptr_q];
      out_valid_d = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      af_q        <= af_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone discard contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.inp;
  end

  assign bus.outp        = outp_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.count       = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic err_ovf_q, err_udf_q;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_q)  err_ovf_q <= 1'b1;
      if (bus.rd_en && empty_q) err_udf_q <= 1'b1;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_udf = err_udf_q;
`endif
endmodule

// File: tb/tb_mod_fifo_n.sv
// Directed bench for mod_fifo_n: reset, fill/drain, wrap, simultaneous push/pop.
module tb_mod_fifo_n;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mod_fifo_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mod_fifo_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Inputs change on the falling edge; outputs are observed on the next falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bus.wr_en = w;
    bus.inp   = d;
    bus.rd_en = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    resetn = 1'b0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.outp !== 8'h00) begin bad++; $display("FAIL reset_outp got=%h exp=00", bus.outp); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b1);
    total++; if (bus.outp !== 8'h11 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL prereset_pop got=%h/%b exp=11/1", bus.outp, bus.out_valid);
    end
    bus.wr_en = 1'b1; bus.inp = 8'h44; bus.rd_en = 1'b0;
    #2 resetn = 1'b1;
    #1;
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      bad++; $display("FAIL midreset_flags got=cnt%0d e%b f%b af%b exp=cnt0 e1 f0 af0",
                      bus.count, bus.empty, bus.full, bus.almost_full);
    end
    total++; if (bus.outp !== 8'h00 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_out got=%h/%b exp=00/0", bus.outp, bus.out_valid);
    end
    bus.wr_en = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    total++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL postreset_empty got=%b/%b exp=1/0", bus.empty, bus.out_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      total++; if (bus.count !== 5'(i+1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, i+1); end
      total++; if (bus.almost_full !== ((i+1) >= 14)) begin bad++; $display("FAIL fill_af i=%0d got=%b", i, bus.almost_full); end
      total++; if (bus.full !== ((i+1) == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b", i, bus.full); end
    end
    step(1'b1, 8'hAA, 1'b0);
    total++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
      bad++; $display("FAIL push_on_full got=cnt%0d f%b exp=cnt16 f1", bus.count, bus.full);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (bus.outp !== 8'(i) || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL drain_data i=%0d got=%h/%b exp=%h/1", i, bus.outp, bus.out_valid, 8'(i));
      end
      total++; if (bus.count !== 5'(15-i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, bus.count, 15-i); end
    end
    step(1'b0, 8'h00, 1'b0);
    total++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.outp !== 8'h0F) begin
      bad++; $display("FAIL drain_end got=e%b v%b %h exp=e1 v0 0f", bus.empty, bus.out_valid, bus.outp);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (bus.outp !== 8'(8'h40 + i)) begin bad++; $display("FAIL wrap_pre i=%0d got=%h exp=%h", i, bus.outp, 8'(8'h40 + i)); end
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    total++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      bad++; $display("FAIL wrap_full got=f%b cnt%0d exp=f1 cnt16", bus.full, bus.count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (bus.outp !== 8'(8'h20 + i) || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL wrap_data i=%0d got=%h/%b exp=%h/1", i, bus.outp, bus.out_valid, 8'(8'h20 + i));
      end
    end
    step(1'b0, 8'h00, 1'b0);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_push_pop_empty();
    step(1'b1, 8'h5A, 1'b1);
    total++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd1 || bus.empty !== 1'b0) begin
      bad++; $display("FAIL pp_empty got=v%b cnt%0d e%b exp=v0 cnt1 e0", bus.out_valid, bus.count, bus.empty);
    end
    step(1'b0, 8'h00, 1'b1);
    total++; if (bus.outp !== 8'h5A || bus.out_valid !== 1'b1 || bus.count !== 5'd0) begin
      bad++; $display("FAIL pp_empty_pop got=%h v%b cnt%0d exp=5a v1 cnt0", bus.outp, bus.out_valid, bus.count);
    end
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    total++; if (bus.outp !== 8'h60 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL pp_full_data got=%h/%b exp=60/1", bus.outp, bus.out_valid);
    end
    total++; if (bus.count !== 5'd15 || bus.full !== 1'b0 || bus.almost_full !== 1'b1) begin
      bad++; $display("FAIL pp_full_count got=cnt%0d f%b af%b exp=cnt15 f0 af1", bus.count, bus.full, bus.almost_full);
    end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (bus.outp !== 8'(8'h60 + i)) begin bad++; $display("FAIL pp_full_rest i=%0d got=%h exp=%h", i, bus.outp, 8'(8'h60 + i)); end
    end
    step(1'b0, 8'h00, 1'b1);
    total++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.outp !== 8'h6F) begin
      bad++; $display("FAIL pp_full_dropped got=e%b v%b %h exp=e1 v0 6f", bus.empty, bus.out_valid, bus.outp);
    end
    step(1'b0, 8'h00, 1'b0);
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    total++; if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      bad++; $display("FAIL err_reset got=%b%b exp=00", bus.err_ovf, bus.err_udf);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    total++; if (bus.err_udf !== 1'b1 || bus.err_ovf !== 1'b0) begin
      bad++; $display("FAIL err_udf got=ovf%b udf%b exp=ovf0 udf1", bus.err_ovf, bus.err_udf);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    total++; if (bus.err_ovf !== 1'b0) begin bad++; $display("FAIL err_ovf_early got=%b exp=0", bus.err_ovf); end
    step(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    total++; if (bus.err_ovf !== 1'b1 || bus.err_udf !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=ovf%b udf%b exp=ovf1 udf1", bus.err_ovf, bus.err_udf);
    end
    total++; if (bus.count !== 5'd13) begin bad++; $display("FAIL err_noblock got=%0d exp=13", bus.count); end
    do_reset();
    total++; if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%b%b exp=00", bus.err_ovf, bus.err_udf);
    end
  endtask
`endif

  initial begin
    resetn    = 1'b1;
    bus.wr_en = 1'b0;
    bus.inp   = 8'h00;
    bus.rd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_push_pop_empty();
    test_push_pop_full();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
